// File: rtl/iomem_router.sv
`default_nettype none
// =============================================================================
// iomem_router : routes the picosoc iomem port to NUM_SLAVES paged peripherals,
//                with a per-access ready timeout and an error log.
// Revision     : 1.0
// =============================================================================
module iomem_router #(
   parameter int         NUM_SLAVES = 4,
   parameter logic [7:0] BASE_PAGE  = 8'h03,
   parameter int         TIMEOUT    = 255
) (
   input  logic                     CLK,
   input  logic                     resetn,
   input  logic                     m_valid,
   output logic                     m_ready,
   input  logic [3:0]               m_wstrb,
   input  logic [31:0]              m_addr,
   input  logic [31:0]              m_wdata,
   output logic [31:0]              m_rdata,
   output logic [NUM_SLAVES-1:0]    s_valid,
   input  logic [NUM_SLAVES-1:0]    s_ready,
   input  logic [32*NUM_SLAVES-1:0] s_rdata,
   output logic [3:0]               s_wstrb,
   output logic [31:0]              s_addr,
   output logic [31:0]              s_wdata,
   output logic                     err_pulse,
   output logic [31:0]              err_addr,
   output logic [7:0]               err_count
);

   localparam logic [7:0] c_last_cnt   = 8'(TIMEOUT - 1);
   localparam logic [7:0] c_num_slaves = 8'(NUM_SLAVES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  r_state;
   logic [7:0]              r_cnt;
   logic                    r_m_ready;
   logic [31:0]             r_m_rdata;
   logic [NUM_SLAVES-1:0]   r_s_valid;
   logic [3:0]              r_s_wstrb;
   logic [31:0]             r_s_addr;
   logic [31:0]             r_s_wdata;
   logic                    r_err_pulse;
   logic [31:0]             r_err_addr;
   logic [7:0]              r_err_count;

   logic [7:0]              w_idx;
   logic                    w_mapped;
   logic [NUM_SLAVES-1:0]   w_onehot;
   logic                    w_sel_ready;
   logic [31:0]             w_sel_rdata;
   logic [7:0]              w_err_count_inc;

   assign w_idx           = m_addr[31:24] - BASE_PAGE;
   assign w_mapped        = (w_idx < c_num_slaves);
   assign w_err_count_inc = (r_err_count == 8'hFF) ? 8'hFF : r_err_count + 8'd1;

   // s_valid is one-hot in BUSY, so masking by it selects the active slave only
   always_comb begin
      w_onehot    = '0;
      w_sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         w_onehot[i] = (w_idx == 8'(i));
         if (r_s_valid[i])
            w_sel_rdata = w_sel_rdata | s_rdata[32*i +: 32];
      end
      w_sel_ready = |(s_ready & r_s_valid);
   end

   always_ff @(posedge CLK) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_m_ready   <= 1'b0;
         r_m_rdata   <= '0;
         r_s_valid   <= '0;
         r_s_wstrb   <= '0;
         r_s_addr    <= '0;
         r_s_wdata   <= '0;
         r_err_pulse <= 1'b0;
         r_err_addr  <= '0;
         r_err_count <= '0;
      end else begin
         r_m_ready   <= 1'b0;
         r_err_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               if (m_valid) begin
                  r_s_addr  <= m_addr;
                  r_s_wstrb <= m_wstrb;
                  r_s_wdata <= m_wdata;
                  r_cnt     <= '0;
                  if (w_mapped) begin
                     r_s_valid <= w_onehot;
                     r_state   <= BUSY;
                  end else begin
                     r_m_rdata   <= 32'hFFFF_FFFF;
                     r_m_ready   <= 1'b1;
                     r_err_pulse <= 1'b1;
                     r_err_addr  <= m_addr;
                     r_err_count <= w_err_count_inc;
                     r_state     <= RESP;
                  end
               end
            end
            BUSY: begin
               // ready is tested first so it wins over a timeout in the same cycle
               if (w_sel_ready) begin
                  r_m_rdata <= w_sel_rdata;
                  r_s_valid <= '0;
                  r_m_ready <= 1'b1;
                  r_state   <= RESP;
               end else if (r_cnt == c_last_cnt) begin
                  r_m_rdata   <= 32'hFFFF_FFFF;
                  r_s_valid   <= '0;
                  r_m_ready   <= 1'b1;
                  r_err_pulse <= 1'b1;
                  r_err_addr  <= r_s_addr;
                  r_err_count <= w_err_count_inc;
                  r_state     <= RESP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            RESP: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign m_ready   = r_m_ready;
   assign m_rdata   = r_m_rdata;
   assign s_valid   = r_s_valid;
   assign s_wstrb   = r_s_wstrb;
   assign s_addr    = r_s_addr;
   assign s_wdata   = r_s_wdata;
   assign err_pulse = r_err_pulse;
   assign err_addr  = r_err_addr;
   assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_iomem_router.sv
`default_nettype none
// tb_iomem_router : randomized transactions checked against a transaction-level
// model of page decode, latency, timeout and the error log.
module tb_iomem_router;

   localparam int         NS = 4;
   localparam logic [7:0] BP = 8'h03;
   localparam int         TO = 255;

   logic              CLK = 1'b0;
   logic              resetn;
   logic              m_valid;
   logic              m_ready;
   logic [3:0]        m_wstrb;
   logic [31:0]       m_addr;
   logic [31:0]       m_wdata;
   logic [31:0]       m_rdata;
   logic [NS-1:0]     s_valid;
   logic [NS-1:0]     s_ready;
   logic [32*NS-1:0]  s_rdata;
   logic [3:0]        s_wstrb;
   logic [31:0]       s_addr;
   logic [31:0]       s_wdata;
   logic              err_pulse;
   logic [31:0]       err_addr;
   logic [7:0]        err_count;

   iomem_router #(.NUM_SLAVES(NS), .BASE_PAGE(BP), .TIMEOUT(TO)) dut (
      .CLK(CLK), .resetn(resetn),
      .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata),
      .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata),
      .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
      .err_pulse(err_pulse), .err_addr(err_addr), .err_count(err_count)
   );

   always #5 CLK = ~CLK;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          mdl_err_count = 0;
   logic [31:0] mdl_err_addr  = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_m_ready"},   32'(m_ready),   32'd0);
      check({tag, "_s_valid"},   32'(s_valid),   32'd0);
      check({tag, "_m_rdata"},   m_rdata,        32'd0);
      check({tag, "_s_addr"},    s_addr,         32'd0);
      check({tag, "_s_wdata"},   s_wdata,        32'd0);
      check({tag, "_s_wstrb"},   32'(s_wstrb),   32'd0);
      check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
      check({tag, "_err_addr"},  err_addr,       32'd0);
      check({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   // Called at a negedge with the DUT idle; returns one cycle after m_ready.
   // delay = number of BUSY cycles before the slave raises ready.
   task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [31:0] wdata, input int delay, input bit drop_valid,
                          input bit fix_rd, input logic [31:0] fix_val);
      int          sel;
      int          exp_lat;
      int          lat;
      int          busy_bad;
      bit          mapped;
      bit          err;
      logic [31:0] exp_rdata;
      logic [NS-1:0] onehot;
      logic [NS-1:0] noise;

      sel    = int'(addr[31:24]) - int'(BP);
      mapped = (sel >= 0) && (sel < NS);
      for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = $urandom;
      if (mapped && fix_rd) s_rdata[32*sel +: 32] = fix_val;

      onehot = '0;
      if (!mapped) begin
         exp_lat = 1; err = 1'b1; exp_rdata = 32'hFFFF_FFFF;
      end else begin
         onehot[sel] = 1'b1;
         if (delay < TO) begin
            exp_lat = 2 + delay; err = 1'b0; exp_rdata = s_rdata[32*sel +: 32];
         end else begin
            exp_lat = TO + 1; err = 1'b1; exp_rdata = 32'hFFFF_FFFF;
         end
      end
      if (err) begin
         if (mdl_err_count < 255) mdl_err_count++;
         mdl_err_addr = addr;
      end

      m_valid = 1'b1; m_addr = addr; m_wstrb = wstrb; m_wdata = wdata; s_ready = '0;
      lat = -1; busy_bad = 0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge CLK);
         if (m_ready) begin
            lat = k;
            break;
         end
         if (k == 1) begin
            check("s_addr",  s_addr,         addr);
            check("s_wdata", s_wdata,        wdata);
            check("s_wstrb", 32'(s_wstrb),   32'(wstrb));
         end
         if (s_valid !== onehot) busy_bad++;
         if (drop_valid) m_valid = 1'b0;
         noise   = NS'($urandom) & ~onehot;
         s_ready = noise;
         if (mapped && (k - 1 == delay)) s_ready = s_ready | onehot;
      end
      check("m_ready_seen", 32'(lat > 0), 32'd1);
      check("latency",      32'(lat), 32'(exp_lat));
      check("m_rdata",      m_rdata, exp_rdata);
      check("err_pulse",    32'(err_pulse), 32'(err));
      check("err_count",    32'(err_count), 32'(mdl_err_count));
      check("err_addr",     err_addr, mdl_err_addr);
      check("s_valid_resp", 32'(s_valid), 32'd0);
      check("busy_onehot",  32'(busy_bad), 32'd0);

      m_valid = 1'b0; s_ready = '0;
      @(negedge CLK);
      check("m_ready_once", 32'(m_ready),   32'd0);
      check("err_one_cyc",  32'(err_pulse), 32'd0);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [7:0] page;
      int         r;
      r = $urandom_range(0, 9);
      if (r < 7) page = BP + 8'($urandom_range(0, NS - 1));
      else if (r == 7) page = BP + 8'(NS);
      else if (r == 8) page = BP - 8'd1;
      else page = 8'($urandom);
      return {page, 24'($urandom)};
   endfunction

   initial begin
      int          d;
      logic [31:0] a;

      resetn = 1'b0; m_valid = 1'b0; m_addr = '0; m_wstrb = '0; m_wdata = '0;
      s_ready = '0; s_rdata = '0;
      repeat (3) @(negedge CLK);
      check_reset_state("rst");
      resetn = 1'b1;
      @(negedge CLK);

      // directed: immediate read, delayed write, unmapped, timeout edge pair, dropped valid
      run_txn(32'h0300_0000, 4'h0, 32'h0,          0, 1'b0, 1'b1, 32'h1234_5678);
      run_txn(32'h0500_0010, 4'hF, 32'h0000_0001,  5, 1'b0, 1'b0, 32'h0);
      run_txn(32'h0900_0000, 4'h0, 32'h0,          0, 1'b0, 1'b0, 32'h0);
      run_txn(32'h0400_0000, 4'h0, 32'h0,         TO, 1'b0, 1'b0, 32'h0);
      run_txn(32'h0400_0004, 4'h0, 32'h0,     TO - 1, 1'b0, 1'b1, 32'hCAFE_F00D);
      run_txn(32'h0600_0020, 4'h3, 32'hA5A5_5A5A,  3, 1'b1, 1'b0, 32'h0);

      for (int n = 0; n < 80; n++) begin
         a = rand_addr();
         if ($urandom_range(0, 9) == 0) d = TO - 2 + $urandom_range(0, 3);
         else d = $urandom_range(0, 6);
         run_txn(a, 4'($urandom), $urandom, d, ($urandom_range(0, 7) == 0), 1'b0, 32'h0);
      end

      // reset while BUSY aborts the access with no completion or error strobe
      m_valid = 1'b1; m_addr = 32'h0400_0100; m_wstrb = 4'h0; m_wdata = '0; s_ready = '0;
      repeat (3) @(negedge CLK);
      check("busy_before_rst", 32'(s_valid), 32'b0010);
      resetn = 1'b0;
      @(negedge CLK);
      check_reset_state("rst_busy");
      resetn = 1'b1; m_valid = 1'b0;
      mdl_err_count = 0; mdl_err_addr = '0;
      d = 0;
      repeat (6) begin
         @(negedge CLK);
         if (m_ready || err_pulse || (s_valid != '0)) d++;
      end
      check("no_resp_after_rst", 32'(d), 32'd0);

      for (int n = 0; n < 300; n++)
         run_txn({8'h09, 24'(n)}, 4'h0, 32'h0, 0, 1'b0, 1'b0, 32'h0);
      check("err_saturated", 32'(err_count), 32'h0000_00FF);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/iomem_router.md
IOMEM_ROUTER -- requirements
Module: iomem_router

Interface
REQ-001 Parameter NUM_SLAVES, default 4: number of peripheral ports (1..8).
REQ-002 Parameter BASE_PAGE, default 8'h03: slave i decodes m_addr[31:24] == BASE_PAGE + i.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles a slave may hold off ready (1..255).
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 resetn  input  1  reset, synchronous, active-low; clock CLK.
REQ-006 m_valid  input  1  request from picosoc iomem port; held until m_ready.
REQ-007 m_ready  output  1  one-cycle completion strobe to master.
REQ-008 m_wstrb  input  4  byte write strobes; 0 = read.
REQ-009 m_addr  input  32  byte address.
REQ-010 m_wdata  input  32  write data.
REQ-011 m_rdata  output  32  read data, valid while m_ready = 1.
REQ-012 s_valid  output  NUM_SLAVES  one-hot request to the selected slave.
REQ-013 s_ready  input  NUM_SLAVES  per-slave completion.
REQ-014 s_rdata  input  32*NUM_SLAVES  slave i read data on bits [32*i+31:32*i].
REQ-015 s_wstrb / s_addr / s_wdata  output  4 / 32 / 32  registered copies of the request, broadcast to all slaves.
REQ-016 err_pulse  output  1  one-cycle strobe on unmapped access or timeout.
REQ-017 err_addr  output  32  address of the most recent erroring access.
REQ-018 err_count  output  8  saturating count of errors since reset.

Function
REQ-019 The block SHALL implement FSM states IDLE, BUSY, RESP.
REQ-020 In IDLE with m_valid = 1, the block SHALL register m_addr, m_wstrb and m_wdata into s_addr, s_wstrb and s_wdata, and SHALL decode the slave index as m_addr[31:24] - BASE_PAGE.
REQ-021 IDLE, decoded index < NUM_SLAVES: SHALL set s_valid[index] = 1, clear the timeout counter, and go to BUSY.
REQ-022 IDLE, unmapped page: SHALL go to RESP with m_rdata = 32'hFFFF_FFFF, pulse err_pulse, latch err_addr, and increment err_count; s_valid stays 0.
REQ-023 BUSY: s_valid SHALL stay one-hot and stable; only s_ready of the selected slave is observed, and other slaves' ready is ignored.
REQ-024 BUSY with selected s_ready = 1: SHALL capture that slave's s_rdata slice into m_rdata, clear s_valid, and go to RESP.
REQ-025 BUSY with counter == TIMEOUT-1 and no ready: SHALL clear s_valid, set m_rdata = 32'hFFFF_FFFF, pulse err_pulse, latch err_addr, increment err_count, and go to RESP.
REQ-026 If s_ready is sampled in the same cycle the timeout fires, ready SHALL win and no error is raised.
REQ-027 RESP: m_ready SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; m_ready SHALL never assert in IDLE or BUSY.
REQ-028 Latency SHALL be: m_valid seen in cycle 0, s_valid high in cycle 1, and if s_ready = 1 in cycle 1 then m_ready high in cycle 2; the unmapped path has m_ready high in cycle 1.
REQ-029 After RESP, IDLE SHALL accept a new request no earlier than the following cycle; back-to-back requests SHALL each complete exactly once.
REQ-030 err_count SHALL saturate at 8'hFF and SHALL not wrap.
REQ-031 A write to a slave SHALL not modify m_rdata beyond the captured slave slice; read data on writes is don't-care to the master but is still captured.
REQ-032 Deassertion of m_valid while in BUSY is a protocol violation; the block SHALL still complete the sequence to RESP.

Reset
REQ-033 On resetn = 0 at a CLK edge, the FSM SHALL enter IDLE, with m_ready = 0, s_valid = 0, m_rdata = 0, s_addr/s_wstrb/s_wdata = 0, err_pulse = 0, err_addr = 0, err_count = 0, and counter = 0.
REQ-034 Reset asserted in BUSY or RESP SHALL abort the transaction: s_valid drops the next edge, no m_ready and no err_pulse are issued.

Verification
REQ-035 Read from 0x0300_0000, slave 0 ready immediately with rdata 0x1234_5678 -> s_valid = 4'b0001 in cycle 1; m_ready = 1 and m_rdata = 0x1234_5678 in cycle 2.
REQ-036 Write wstrb = 4'hF, addr 0x0500_0010, data 0x1 -> s_valid = 4'b0100, s_addr = 0x0500_0010, s_wdata = 1; slave 2 ready after 5 cycles -> m_ready exactly once.
REQ-037 Access 0x0900_0000 (unmapped, NUM_SLAVES = 4) -> m_ready in cycle 1, m_rdata = 0xFFFF_FFFF, err_pulse = 1, err_addr = 0x0900_0000, err_count = 1.
REQ-038 Slave 1 never ready, TIMEOUT = 255 -> s_valid drops after 255 BUSY cycles; m_ready with 0xFFFF_FFFF; err_count increments; an s_ready on the timeout cycle instead -> normal completion, no error.
REQ-039 Reset pulse in BUSY -> all outputs at reset values, no m_ready; 300 unmapped accesses -> err_count = 0xFF.
